tdes_round_sequencer: RTL and testbench
=======================================

Name: tdes_round_sequencer

Overview:
- Control stage directly upstream of the DES key schedule.
- Holds the three Triple-DES keys and walks the 3-pass x 16-round schedule.
- Each step presents the selected 64-bit key plus a round number to the key schedule, which returns the 48-bit subkey to the round datapath.
- Supports EDE encrypt and DED decrypt ordering, with a valid/ready handshake toward the round datapath.

Parameters:
- ROUNDS, 16, DES rounds per pass; round_number counts 1..ROUNDS.
- KEY_W, 64, width of each DES key including parity bits.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- key_load  input  1  capture key1_in/key2_in/key3_in into key registers
- key1_in  input  64  DES key 1
- key2_in  input  64  DES key 2
- key3_in  input  64  DES key 3
- start  input  1  begin a 48-round Triple-DES operation
- mode  input  1  0 = encrypt (EDE), 1 = decrypt (DED); sampled with start
- round_ready  input  1  datapath has consumed the current round
- key_out  output  64  key feeding the key schedule
- round_number  output  5  current round, 1..16; 0 when idle
- round_valid  output  1  key_out and round_number are valid
- pass_index  output  2  current pass, 0..2
- pass_decrypt  output  1  current pass runs DES decrypt (reverse subkey order)
- last_round  output  1  current round is the final round of pass 2
- busy  output  1  operation in progress (RUN or DONE)
- done  output  1  one-cycle pulse after the final round handshake

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE; key registers = 0.
  - All outputs 0: key_out, round_number, round_valid, pass_index, pass_decrypt, last_round, busy, done.
  - Reset mid-operation aborts immediately; no done pulse.
- Key registers:
  - Written on key_load=1 only while state = IDLE.
  - key_load is ignored in RUN and DONE.
  - key_load and start in the same IDLE cycle: the operation uses the newly loaded keys.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch mode and go to RUN, with pass_index = 0 and the first round of pass 0.
  - round_valid asserts the cycle after start (latency 1).
- Pass schedule, encrypt (mode = 0):
  - P0: key1, encrypt, rounds 1->16.
  - P1: key2, decrypt, rounds 16->1.
  - P2: key3, encrypt, rounds 1->16.
- Pass schedule, decrypt (mode = 1):
  - P0: key3, decrypt, rounds 16->1.
  - P1: key2, encrypt, rounds 1->16.
  - P2: key1, decrypt, rounds 16->1.
- pass_decrypt = 1 exactly on the decrypt passes listed above.
- RUN:
  - round_valid = 1.
  - Advance only on a cycle where round_valid=1 and round_ready=1. Otherwise hold key_out, round_number, pass_index and pass_decrypt stable.
  - Advance within a pass: round_number moves +1 (encrypt pass) or -1 (decrypt pass).
  - At pass end (round 16 on an encrypt pass, round 1 on a decrypt pass): pass_index increments, key_out switches to the next key, and round_number reloads to 1 or 16 per the new pass direction, all in the next cycle with no bubble.
  - last_round = 1 when pass_index = 2 and round_number is the final round of that pass.
  - Handshake on last_round: go to DONE.
- DONE:
  - One cycle with done = 1, busy = 1, round_valid = 0, round_number = 0.
  - Then return to IDLE.
- start is ignored while busy = 1. Changes to mode while busy have no effect.
- round_number never takes the values 0 or 17 while round_valid = 1.
- busy = 1 in RUN and DONE; 0 in IDLE.
- Total operation with round_ready held at 1: 1 cycle start latency + 48 RUN cycles + 1 DONE cycle. done is asserted 49 cycles after the start cycle.

Test Plan:
- Reset then idle -> all outputs 0. key_load with key1=64'h0123456789ABCDEF, then start with mode=0 and round_ready=1 -> next cycle round_valid=1, key_out=64'h0123456789ABCDEF, round_number=1, pass_index=0, pass_decrypt=0.
- Full encrypt run with round_ready held at 1 -> round_number sequence 1..16, 16..1, 1..16; key_out switches key1->key2->key3 at the pass boundaries with no bubble; last_round high on exactly one cycle; done pulses 49 cycles after start; busy drops the following cycle.
- Decrypt run (mode=1) with keys 64'h1111..., 64'h2222..., 64'h3333... -> pass 0 uses key3 with rounds 16..1 and pass_decrypt=1; pass 1 uses key2 with rounds 1..16 and pass_decrypt=0; pass 2 uses key1 with rounds 16..1.
- Stall: drop round_ready for 5 cycles at pass 1, round 9 -> key_out, round_number=9 and pass_index=1 held stable for all 5 cycles; done delayed by exactly 5 cycles.
- Start and key_load while busy, with a new key1 -> no restart and key registers unchanged; a subsequent run after done uses the old key1 until a key_load in IDLE.
- Assert rst during pass 2, round 5 -> the next cycle has all outputs 0, no done pulse, and key registers cleared; a fresh start after a new key_load runs normally.

Source files
------------

// File: rtl/tdes_round_sequencer.sv
// ----------------------------------------------------------------------------
// tdes_round_sequencer
//   Sits directly ahead of the DES key schedule. It holds the three Triple-DES
//   keys and steps through the 3-pass x ROUNDS-round schedule in EDE (encrypt)
//   or DED (decrypt) order. Each step presents one key and one round number,
//   and the step is held until the round datapath accepts it through the
//   valid/ready handshake.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   key_load        capture key1_in/key2_in/key3_in (honoured only in IDLE)
//   key1_in..3_in   DES keys, including parity bits
//   start, mode     begin an operation; mode 0 = EDE encrypt, 1 = DED decrypt
//   round_ready     datapath accepts the current round
//   key_out         key selected for the current pass
//   round_number    1..ROUNDS while valid, 0 otherwise
//   round_valid     key_out / round_number are valid
//   pass_index      current pass, 0..2
//   pass_decrypt    current pass uses reverse subkey order
//   last_round      final round of pass 2
//   busy            operation in progress (RUN or DONE)
//   done            one-cycle pulse after the final handshake
// ----------------------------------------------------------------------------
module tdes_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int KEY_W  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [KEY_W-1:0] key1_in,
  input  logic [KEY_W-1:0] key2_in,
  input  logic [KEY_W-1:0] key3_in,
  input  logic             start,
  input  logic             mode,
  input  logic             round_ready,
  output logic [KEY_W-1:0] key_out,
  output logic [4:0]       round_number,
  output logic             round_valid,
  output logic [1:0]       pass_index,
  output logic             pass_decrypt,
  output logic             last_round,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             mode_r;
  logic [KEY_W-1:0] key1_r, key2_r, key3_r;

  // Encrypt flow runs E-D-E, decrypt flow runs D-E-D.
  function automatic logic pass_is_dec(input logic m, input logic [1:0] p);
    return m ? (p != 2'd1) : (p == 2'd1);
  endfunction

  function automatic logic [KEY_W-1:0] pass_key(input logic m, input logic [1:0] p,
                                                input logic [KEY_W-1:0] k1,
                                                input logic [KEY_W-1:0] k2,
                                                input logic [KEY_W-1:0] k3);
    logic [KEY_W-1:0] k;
    case (p)
      2'd0:    k = m ? k3 : k1;
      2'd1:    k = k2;
      default: k = m ? k1 : k3;
    endcase
    return k;
  endfunction

  function automatic logic [4:0] first_rnd(input logic dec);
    return dec ? LAST_RND : 5'd1;
  endfunction

  function automatic logic [4:0] final_rnd(input logic dec);
    return dec ? 5'd1 : LAST_RND;
  endfunction

  // Effective keys on the start cycle, so a same-cycle key_load takes effect.
  logic [KEY_W-1:0] k1_eff, k2_eff, k3_eff;
  logic [1:0]       next_pass;
  logic             next_dec;
  logic [4:0]       next_rnd;

  always_comb begin
    k1_eff    = key_load ? key1_in : key1_r;
    k2_eff    = key_load ? key2_in : key2_r;
    k3_eff    = key_load ? key3_in : key3_r;
    next_pass = 2'(pass_index + 2'd1);
    next_dec  = pass_is_dec(mode_r, next_pass);
    next_rnd  = pass_decrypt ? 5'(round_number - 5'd1) : 5'(round_number + 5'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mode_r       <= 1'b0;
      key1_r       <= '0;
      key2_r       <= '0;
      key3_r       <= '0;
      key_out      <= '0;
      round_number <= '0;
      round_valid  <= 1'b0;
      pass_index   <= '0;
      pass_decrypt <= 1'b0;
      last_round   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (key_load) begin
            key1_r <= key1_in;
            key2_r <= key2_in;
            key3_r <= key3_in;
          end
          if (start) begin
            state        <= RUN;
            mode_r       <= mode;
            pass_index   <= 2'd0;
            pass_decrypt <= pass_is_dec(mode, 2'd0);
            round_number <= first_rnd(pass_is_dec(mode, 2'd0));
            key_out      <= pass_key(mode, 2'd0, k1_eff, k2_eff, k3_eff);
            round_valid  <= 1'b1;
            last_round   <= 1'b0;
            busy         <= 1'b1;
          end
        end

        RUN: begin
          if (round_ready) begin
            if (last_round) begin
              state        <= DONE;
              round_valid  <= 1'b0;
              round_number <= '0;
              pass_index   <= '0;
              pass_decrypt <= 1'b0;
              last_round   <= 1'b0;
              key_out      <= '0;
              done         <= 1'b1;
            end else if (round_number == final_rnd(pass_decrypt)) begin
              // Pass boundary: switch key and direction in the same step.
              pass_index   <= next_pass;
              pass_decrypt <= next_dec;
              round_number <= first_rnd(next_dec);
              key_out      <= pass_key(mode_r, next_pass, key1_r, key2_r, key3_r);
              last_round   <= (next_pass == 2'd2) && (first_rnd(next_dec) == final_rnd(next_dec));
            end else begin
              round_number <= next_rnd;
              last_round   <= (pass_index == 2'd2) && (next_rnd == final_rnd(pass_decrypt));
            end
          end
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdes_round_sequencer.sv
module tb_tdes_round_sequencer;

  logic        clk = 1'b0;
  logic        rst, key_load, start, mode, round_ready;
  logic [63:0] key1_in, key2_in, key3_in;
  logic [63:0] key_out;
  logic [4:0]  round_number;
  logic        round_valid, pass_decrypt, last_round, busy, done;
  logic [1:0]  pass_index;

  tdes_round_sequencer #(.ROUNDS(16), .KEY_W(64)) dut (
    .clk(clk), .rst(rst), .key_load(key_load),
    .key1_in(key1_in), .key2_in(key2_in), .key3_in(key3_in),
    .start(start), .mode(mode), .round_ready(round_ready),
    .key_out(key_out), .round_number(round_number), .round_valid(round_valid),
    .pass_index(pass_index), .pass_decrypt(pass_decrypt), .last_round(last_round),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        chk_key;
    logic [63:0] key;
    logic [4:0]  rnd;
    logic [1:0]  pidx;
    logic        pd, last, valid, busy, done;
  } vec_t;

  vec_t tbl[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h23456789ABCDEF01;
  localparam logic [63:0] K3 = 64'h456789ABCDEF0123;
  localparam logic [63:0] NK = 64'hFEDCBA9876543210;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    else
      passed++;
  endtask

  function automatic logic [63:0] status();
    return 64'({round_valid, round_number, pass_index, pass_decrypt, last_round, busy, done});
  endfunction

  function automatic logic [63:0] pack(input vec_t v);
    return 64'({v.valid, v.rnd, v.pidx, v.pd, v.last, v.busy, v.done});
  endfunction

  // Expected schedule written as a list of passes, independent of the DUT's stepping logic.
  task automatic build(input logic m, input logic [63:0] k1, k2, k3,
                       input int sp, input int sr, input int slen);
    vec_t v;
    tbl.delete();
    for (int p = 0; p < 3; p++) begin
      logic dec;
      logic [63:0] k;
      dec = m ? (p != 1) : (p == 1);
      k   = (p == 1) ? k2 : ((p == 0) ^ m) ? k1 : k3;
      for (int i = 0; i < 16; i++) begin
        v = '{rdy: 1'b1, chk_key: 1'b1, key: k, rnd: 5'(dec ? 16 - i : i + 1),
              pidx: 2'(p), pd: dec, last: (p == 2 && i == 15),
              valid: 1'b1, busy: 1'b1, done: 1'b0};
        if (p == sp && int'(v.rnd) == sr) begin
          v.rdy = 1'b0;
          for (int s = 0; s < slen; s++) tbl.push_back(v);
          v.rdy = 1'b1;
        end
        tbl.push_back(v);
      end
    end
    v = '{rdy: 1'b1, chk_key: 1'b0, key: '0, rnd: '0, pidx: '0, pd: 1'b0,
          last: 1'b0, valid: 1'b0, busy: 1'b1, done: 1'b1};
    tbl.push_back(v);
    v.busy = 1'b0;
    v.done = 1'b0;
    v.chk_key = 1'b1;
    tbl.push_back(v);
  endtask

  // Noise mode hammers start/key_load/mode during the first RUN cycles.
  task automatic apply(input string name, input bit noise);
    for (int j = 0; j < tbl.size(); j++) begin
      round_ready = tbl[j].rdy;
      if (noise && j < 10) begin
        start = 1'b1; key_load = 1'b1; key1_in = NK; mode = ~mode;
      end else begin
        start = 1'b0; key_load = 1'b0;
      end
      chk({name, "_st"}, j, status(), pack(tbl[j]));
      if (tbl[j].chk_key) chk({name, "_key"}, j, key_out, tbl[j].key);
      tick();
    end
    start = 1'b0; key_load = 1'b0; round_ready = 1'b1;
  endtask

  task automatic start_op(input logic m, input logic load, input logic [63:0] k1, k2, k3);
    key_load = load; key1_in = k1; key2_in = k2; key3_in = k3;
    mode = m; start = 1'b1; round_ready = 1'b1;
    tick();
    start = 1'b0; key_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; key_load = 1'b0; start = 1'b0; mode = 1'b0; round_ready = 1'b0;
    key1_in = '0; key2_in = '0; key3_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_st", 0, status(), 64'd0);
    chk("reset_key", 0, key_out, 64'd0);

    // Encrypt with keys loaded on the start cycle.
    start_op(1'b0, 1'b1, K1, K2, K3);
    build(1'b0, K1, K2, K3, -1, 0, 0);
    apply("enc", 1'b0);

    // Decrypt ordering.
    start_op(1'b1, 1'b1, {16{4'h1}}, {16{4'h2}}, {16{4'h3}});
    build(1'b1, {16{4'h1}}, {16{4'h2}}, {16{4'h3}}, -1, 0, 0);
    apply("dec", 1'b0);

    // Five-cycle stall at pass 1, round 9.
    start_op(1'b0, 1'b1, K1, K2, K3);
    build(1'b0, K1, K2, K3, 1, 9, 5);
    apply("stall", 1'b0);

    // start/key_load/mode activity while busy must be ignored.
    start_op(1'b0, 1'b0, 64'd0, 64'd0, 64'd0);
    build(1'b0, K1, K2, K3, -1, 0, 0);
    apply("busy_ign", 1'b1);
    mode = 1'b0;

    // Next run without key_load still sees the old key1.
    start_op(1'b0, 1'b0, NK, NK, NK);
    build(1'b0, K1, K2, K3, -1, 0, 0);
    apply("oldkey", 1'b0);

    // Reset during pass 2, round 5.
    start_op(1'b0, 1'b1, K1, K2, K3);
    for (int i = 0; i < 36; i++) tick();
    chk("pre_rst_rnd", 0, 64'(round_number), 64'd5);
    chk("pre_rst_pass", 0, 64'(pass_index), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_st", 0, status(), 64'd0);
    chk("rst_key", 0, key_out, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_nodone", i, status(), 64'd0);
    end
    // Keys were cleared, so a start without load presents a zero key.
    start_op(1'b0, 1'b0, NK, NK, NK);
    chk("rst_clr_key", 0, key_out, 64'd0);
    chk("rst_clr_rnd", 0, 64'(round_number), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    start_op(1'b0, 1'b1, K3, K1, K2);
    build(1'b0, K3, K1, K2, -1, 0, 0);
    apply("fresh", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
